// File: rtl/glyph_fetch_scheduler_pkg.sv
// Shared definitions for the glyph fetch scheduler: glyph code values,
// pointer-table strides, the scan FSM encoding and the indicator code mapping.
// No logic; imported by every file of the block.
package glyph_fetch_scheduler_pkg;

  // Glyph codes as understood by the digit pointer table
  localparam logic [3:0] DIGIT_MAX  = 4'd9;
  localparam logic [3:0] CODE_AM    = 4'd10;
  localparam logic [3:0] CODE_PM    = 4'd11;
  localparam logic [3:0] CODE_24H   = 4'd12;
  localparam logic [3:0] CODE_RED   = 4'd13;
  localparam logic [3:0] CODE_GREEN = 4'd14;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  // Rows between consecutive glyphs in the sprite ROMs
  localparam int DIGIT_STRIDE = 60;
  localparam int IND_STRIDE   = 20;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    IDLE_LINE  = 2'd1,
    SCAN       = 2'd2
  } scan_state_t;

  // Indicator mode to glyph code: 0=AM, 1=PM, 2=24H, 3=blank
  function automatic logic [3:0] ind_code(input logic [1:0] mode);
    case (mode)
      2'd0:    ind_code = CODE_AM;
      2'd1:    ind_code = CODE_PM;
      2'd2:    ind_code = CODE_24H;
      default: ind_code = CODE_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/glyph_fetch_scheduler_if.sv
// Bundles the digit-update handshake (upd_req/upd_data/upd_ack) and the
// pointer-table lookup (tbl_value out, tbl_point_y back, combinational).
// master = timekeeping + pointer table side, slave = glyph_fetch_scheduler.
interface glyph_fetch_scheduler_if #(
  parameter int NUM_SLOTS = 8
);
  logic                   upd_req;
  logic [4*NUM_SLOTS-1:0] upd_data;
  logic                   upd_ack;
  logic [3:0]             tbl_value;
  logic [9:0]             tbl_point_y;

  modport master (
    output upd_req, upd_data, tbl_point_y,
    input  upd_ack, tbl_value
  );

  modport slave (
    input  upd_req, upd_data, tbl_point_y,
    output upd_ack, tbl_value
  );
endinterface

// File: rtl/glyph_fetch_scheduler_code_buffer.sv
// glyph_code_buffer: pending/shadow digit banks with req/ack and frame commit.
// Latency: upd_ack one clk after upd_req; shadow changes only on frame_start.
// Backpressure: none, every request is accepted; later data overwrites pending.
// Ports: clk, rst_n, upd_req/upd_data in, upd_ack out, frame_start in,
//        shadow out (slot0 in [3:0]). With INDICATOR_SLOT_EN also
//        ind_mode in / shadow_ind out, buffered the same way.
module glyph_code_buffer #(
  parameter int NUM_SLOTS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   upd_req,
  input  logic [4*NUM_SLOTS-1:0] upd_data,
  input  logic                   frame_start,
`ifdef INDICATOR_SLOT_EN
  input  logic [1:0]             ind_mode,
  output logic [1:0]             shadow_ind,
`endif
  output logic                   upd_ack,
  output logic [4*NUM_SLOTS-1:0] shadow
);

  logic [4*NUM_SLOTS-1:0] pending;
  logic                   pend_full;
`ifdef INDICATOR_SLOT_EN
  logic [1:0]             pending_ind;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      shadow    <= '0;
      pend_full <= 1'b0;
      upd_ack   <= 1'b0;
`ifdef INDICATOR_SLOT_EN
      pending_ind <= '0;
      shadow_ind  <= '0;
`endif
    end else begin
      upd_ack <= upd_req;
      if (upd_req && frame_start) begin
        // Request coincides with the commit point: it goes live this frame.
        pending   <= upd_data;
        shadow    <= upd_data;
        pend_full <= 1'b0;
`ifdef INDICATOR_SLOT_EN
        pending_ind <= ind_mode;
        shadow_ind  <= ind_mode;
`endif
      end else if (upd_req) begin
        pending   <= upd_data;
        pend_full <= 1'b1;
`ifdef INDICATOR_SLOT_EN
        pending_ind <= ind_mode;
`endif
      end else if (frame_start) begin
        // With pend_full clear, pending already equals shadow, so the copy
        // is only needed when something new is waiting.
        if (pend_full) begin
          shadow <= pending;
`ifdef INDICATOR_SLOT_EN
          shadow_ind <= pending_ind;
`endif
        end
        pend_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/glyph_fetch_scheduler.sv
// glyph_fetch_scheduler: walks the glyph band per raster line, feeds digit codes
// to the pointer table and forms sprite-ROM addresses.
// Latency: 2 pix_ticks from a pixel to rom_addr/pix_valid; outputs hold between
// ticks. Backpressure: none, raster-driven; updates never stall the requester.
// Ports: clk, rst_n, pix_tick, pixel_x/pixel_y, frame_start; bus (slave modport:
//        upd_req/upd_data/upd_ack, tbl_value/tbl_point_y); rom_addr, pix_valid,
//        busy. Macro INDICATOR_SLOT_EN adds ind_mode in and rom_sel out.
module glyph_fetch_scheduler
  import glyph_fetch_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 32,
  parameter int SLOT_H    = 60,
  parameter int X0        = 64,
  parameter int Y0        = 200,
  parameter int ADDR_W    = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pix_tick,
  input  logic [9:0]           pixel_x,
  input  logic [9:0]           pixel_y,
  input  logic                 frame_start,
  glyph_fetch_scheduler_if.slave bus,
  output logic [ADDR_W-1:0]    rom_addr,
  output logic                 pix_valid,
  output logic                 busy
`ifdef INDICATOR_SLOT_EN
  ,
  input  logic [1:0]           ind_mode,
  output logic                 rom_sel
`endif
);

  localparam int COL_W = $clog2(SLOT_W);
  localparam int ROW_W = $clog2(SLOT_H);
  localparam int HI_W  = ADDR_W - COL_W;

  localparam logic [9:0] X_START = 10'(X0 - 1);
  localparam logic [9:0] Y_LO    = 10'(Y0);
  localparam logic [9:0] Y_HI    = 10'(Y0 + SLOT_H);
`ifdef INDICATOR_SLOT_EN
  localparam logic [3:0] LAST_SLOT = 4'(NUM_SLOTS);
`else
  localparam logic [3:0] LAST_SLOT = 4'(NUM_SLOTS - 1);
`endif

  // ---------------------------------------------------------------------------
  // Digit code double buffer
  // ---------------------------------------------------------------------------
  logic [4*NUM_SLOTS-1:0] shadow;
`ifdef INDICATOR_SLOT_EN
  logic [1:0]             shadow_ind;
`endif

  glyph_code_buffer #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_code_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .upd_req     (bus.upd_req),
    .upd_data    (bus.upd_data),
    .frame_start (frame_start),
`ifdef INDICATOR_SLOT_EN
    .ind_mode    (ind_mode),
    .shadow_ind  (shadow_ind),
`endif
    .upd_ack     (bus.upd_ack),
    .shadow      (shadow)
  );

  // ---------------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------------
  scan_state_t      state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [3:0]       slot_q, slot_d;
  logic [ROW_W-1:0] row_q, row_d;

  logic start_line;
  assign start_line = pix_tick && (pixel_x == X_START) &&
                      (pixel_y >= Y_LO) && (pixel_y < Y_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_FRAME;
      col_q   <= '0;
      slot_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      slot_q  <= slot_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    slot_d  = slot_q;
    row_d   = row_q;
    case (state_q)
      WAIT_FRAME: begin
        if (frame_start) state_d = IDLE_LINE;
      end
      IDLE_LINE: begin
        if (start_line) begin
          row_d   = ROW_W'(pixel_y - Y_LO);
          col_d   = '0;
          slot_d  = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (frame_start) begin
          state_d = IDLE_LINE;
        end else if (pix_tick) begin
          if (col_q == COL_W'(SLOT_W - 1)) begin
            col_d = '0;
            // Slot stays put on the final wrap so it never points past the band.
            if (slot_q == LAST_SLOT) state_d = IDLE_LINE;
            else                     slot_d  = slot_q + 4'd1;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      default: state_d = WAIT_FRAME;
    endcase
  end

  assign busy = (state_q == SCAN);

  // ---------------------------------------------------------------------------
  // Slot code select
  // ---------------------------------------------------------------------------
  logic [3:0] code_sel;
  always_comb begin
    code_sel = 4'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_q == 4'(i)) code_sel = shadow[i*4 +: 4];
    end
`ifdef INDICATOR_SLOT_EN
    if (slot_q == LAST_SLOT) code_sel = ind_code(shadow_ind);
`endif
  end

  // ---------------------------------------------------------------------------
  // Stage 1: code/col/row capture; code drives the pointer table
  // ---------------------------------------------------------------------------
  logic [3:0]       code1;
  logic [COL_W-1:0] col1;
  logic [ROW_W-1:0] row1;
  logic             v1;
`ifdef INDICATOR_SLOT_EN
  logic             ind1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code1 <= '0;
      col1  <= '0;
      row1  <= '0;
      v1    <= 1'b0;
`ifdef INDICATOR_SLOT_EN
      ind1  <= 1'b0;
`endif
    end else if (pix_tick) begin
      code1 <= code_sel;
      col1  <= col_q;
      row1  <= row_q;
      v1    <= (state_q == SCAN);
`ifdef INDICATOR_SLOT_EN
      ind1  <= (slot_q == LAST_SLOT);
`endif
    end
  end

  assign bus.tbl_value = code1;

  // ---------------------------------------------------------------------------
  // Stage 2: sprite-ROM address and pixel qualifier
  // ---------------------------------------------------------------------------
  logic [HI_W-1:0] addr_hi;
  logic            valid_d;

  always_comb begin
    addr_hi = HI_W'(bus.tbl_point_y) + HI_W'(row1);
    valid_d = v1 && (code1 <= DIGIT_MAX);
`ifdef INDICATOR_SLOT_EN
    // Indicator glyphs live in their own 20-row ROM band, indexed from AM.
    if (ind1) begin
      addr_hi = HI_W'((code1 - CODE_AM) * IND_STRIDE) + HI_W'(row1);
      valid_d = v1 && (row1 < ROW_W'(IND_STRIDE)) && (code1 != CODE_BLANK);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      pix_valid <= 1'b0;
`ifdef INDICATOR_SLOT_EN
      rom_sel   <= 1'b0;
`endif
    end else if (pix_tick) begin
      rom_addr  <= {addr_hi, col1};
      pix_valid <= valid_d;
`ifdef INDICATOR_SLOT_EN
      rom_sel   <= v1 && ind1;
`endif
    end
  end

endmodule
